// File: rtl/packet_to_serial.sv
// Transmit framer: buffers one packet, then emits 0x51, 16-bit length (MSB first), payload.
// Header appears the cycle after in_last is accepted; output holds steady while out_ready is low.
module packet_to_serial #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       overflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_HDR,
    S_LEN_HI,
    S_LEN_LO,
    S_PAYLOAD
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  live_q, live_d;
  logic [7:0]            mem [DEPTH];
  logic [7:0]            rdata_q;
  logic                  wr_en;
  logic [15:0]           len16;

  assign len16 = {{(16-CW){1'b0}}, count_q};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    live_d     = 1'b1;
    wr_en      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;

    case (state_q)
      S_COLLECT: begin
        // live_q keeps in_ready low until the first edge after reset release
        in_ready = live_q;
        if (in_valid && live_q) begin
          if (count_q < DEPTH_C) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (in_last) state_d = S_HDR;
        end
      end
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = 8'h51;
        if (out_ready) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        out_valid = 1'b1;
        out_data  = len16[15:8];
        if (out_ready) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        out_valid = 1'b1;
        out_data  = len16[7:0];
        rd_ptr_d  = '0;
        if (out_ready) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        out_valid = 1'b1;
        out_data  = rdata_q;
        if (out_ready) begin
          if ({1'b0, rd_ptr_q} == count_q - CW'(1)) begin
            state_d  = S_COLLECT;
            count_d  = '0;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= S_COLLECT;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      live_q     <= live_d;
    end
  end

  // Read address is the next pointer, so rdata_q tracks rd_ptr_q with no bubble
  always_ff @(posedge clock) begin
    if (wr_en) mem[count_q[ADDR_WIDTH-1:0]] <= in_data;
    rdata_q <= mem[rd_ptr_d];
  end

  assign overflow = overflow_q;

endmodule
